// File: rtl/noc_switch_allocator.sv
// Switch allocator for a 5-port mesh router: per-output round-robin arbitration,
// wormhole locking and downstream credit tracking.
module noc_switch_allocator #(
  parameter int BUF_DEPTH = 4,
  parameter int CW        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  req_valid,
  input  logic [14:0] req_dest,
  input  logic [4:0]  req_tail,
  input  logic [4:0]  credit_inc,
  output logic [4:0]  in_pop,
  output logic [4:0]  out_en,
  output logic [14:0] out_sel,
  output logic [4:0]  out_locked,
  output logic        credit_err
);

  localparam int NP = 5;

  typedef enum logic {IDLE, LOCKED} lock_state_t;

  lock_state_t   state_q [NP];
  lock_state_t   state_d [NP];
  logic [2:0]    ptr_q   [NP];
  logic [2:0]    ptr_d   [NP];
  logic [2:0]    own_q   [NP];
  logic [2:0]    own_d   [NP];
  logic [CW-1:0] cred_q  [NP];
  logic [CW-1:0] cred_d  [NP];
  logic          err_q;
  logic          err_d;

  logic [NP-1:0] req_mat [NP];
  logic [NP-1:0] gnt;
  logic [2:0]    src     [NP];

  function automatic logic [2:0] next_port(input logic [2:0] p);
    return (p == 3'd4) ? 3'd0 : p + 3'd1;
  endfunction

  // Out-of-range destinations and U-turns never match any output column.
  always_comb begin : request_matrix
    for (int o = 0; o < NP; o++) begin
      req_mat[o] = '0;
      for (int i = 0; i < NP; i++) begin
        req_mat[o][i] = req_valid[i] && (req_dest[3*i +: 3] == 3'(o)) && (i != o);
      end
    end
  end

  always_comb begin : arbitration
    logic [3:0] cand;
    cand = '0;
    for (int o = 0; o < NP; o++) begin
      gnt[o] = 1'b0;
      src[o] = 3'd0;
      if (!rst && cred_q[o] != '0) begin
        if (state_q[o] == LOCKED) begin
          if (req_mat[o][own_q[o]]) begin
            gnt[o] = 1'b1;
            src[o] = own_q[o];
          end
        end else begin
          for (int k = 0; k < NP; k++) begin
            cand = 4'(ptr_q[o]) + 4'(k);
            if (cand >= 4'd5) cand = cand - 4'd5;
            if (!gnt[o] && req_mat[o][cand[2:0]]) begin
              gnt[o] = 1'b1;
              src[o] = cand[2:0];
            end
          end
        end
      end
    end
  end

  always_comb begin : outputs
    in_pop     = '0;
    out_en     = gnt;
    out_sel    = '1;
    out_locked = '0;
    for (int o = 0; o < NP; o++) begin
      if (gnt[o]) begin
        in_pop[src[o]]    = 1'b1;
        out_sel[3*o +: 3] = src[o];
      end
      out_locked[o] = !rst && (state_q[o] == LOCKED);
    end
    credit_err = err_q && !rst;
  end

  // The pointer only moves when a packet completes, so a locked packet is never preempted.
  always_comb begin : next_state
    err_d = err_q;
    for (int o = 0; o < NP; o++) begin
      state_d[o] = state_q[o];
      ptr_d[o]   = ptr_q[o];
      own_d[o]   = own_q[o];
      cred_d[o]  = cred_q[o];
      if (gnt[o]) begin
        if (state_q[o] == IDLE) begin
          if (req_tail[src[o]]) begin
            ptr_d[o] = next_port(src[o]);
          end else begin
            state_d[o] = LOCKED;
            own_d[o]   = src[o];
          end
        end else if (req_tail[src[o]]) begin
          state_d[o] = IDLE;
          ptr_d[o]   = next_port(own_q[o]);
        end
      end
      if (gnt[o] && !credit_inc[o]) begin
        cred_d[o] = cred_q[o] - CW'(1);
      end else if (!gnt[o] && credit_inc[o]) begin
        if (cred_q[o] == CW'(BUF_DEPTH)) begin
          err_d = 1'b1;
        end else begin
          cred_d[o] = cred_q[o] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin : state_register
    if (rst) begin
      err_q <= 1'b0;
      for (int o = 0; o < NP; o++) begin
        state_q[o] <= IDLE;
        ptr_q[o]   <= 3'd0;
        own_q[o]   <= 3'd0;
        cred_q[o]  <= CW'(BUF_DEPTH);
      end
    end else begin
      err_q <= err_d;
      for (int o = 0; o < NP; o++) begin
        state_q[o] <= state_d[o];
        ptr_q[o]   <= ptr_d[o];
        own_q[o]   <= own_d[o];
        cred_q[o]  <= cred_d[o];
      end
    end
  end

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Scoreboard bench for noc_switch_allocator: a behavioural reference model queues the
// expected grant pattern for each driven cycle, and directed checks pin the key scenarios.
module tb_noc_switch_allocator;

  localparam int BUF_DEPTH = 4;
  localparam int CW        = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  req_valid = '0;
  logic [14:0] req_dest = '0;
  logic [4:0]  req_tail = '0;
  logic [4:0]  credit_inc = '0;
  logic [4:0]  in_pop;
  logic [4:0]  out_en;
  logic [14:0] out_sel;
  logic [4:0]  out_locked;
  logic        credit_err;

  noc_switch_allocator #(.BUF_DEPTH(BUF_DEPTH), .CW(CW)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_dest(req_dest),
    .req_tail(req_tail),
    .credit_inc(credit_inc),
    .in_pop(in_pop),
    .out_en(out_en),
    .out_sel(out_sel),
    .out_locked(out_locked),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  pop;
    logic [4:0]  en;
    logic [14:0] sel;
    logic [4:0]  locked;
    logic        err;
  } exp_t;

  exp_t expQ[$];
  int numChecks = 0;
  int numPassed = 0;

  int mCred[5];
  int mPtr[5];
  int mOwn[5];
  bit mLock[5];
  bit mErr;
  int gsrc[5];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    else
      numPassed++;
  endtask

  function automatic logic [14:0] dst(input int d0, input int d1, input int d2, input int d3, input int d4);
    return {3'(d4), 3'(d3), 3'(d2), 3'(d1), 3'(d0)};
  endfunction

  function automatic bit wantsOut(input int i, input int o);
    return req_valid[i] && (int'(req_dest[3*i +: 3]) == o) && (i != o);
  endfunction

  // Reference arbitration on the model's current state and the driven inputs.
  task automatic modelGrants();
    for (int o = 0; o < 5; o++) begin
      gsrc[o] = -1;
      if (rst == 1'b0 && mCred[o] > 0) begin
        if (mLock[o]) begin
          if (wantsOut(mOwn[o], o)) gsrc[o] = mOwn[o];
        end else begin
          for (int k = 0; k < 5; k++) begin
            if (gsrc[o] < 0 && wantsOut((mPtr[o] + k) % 5, o)) gsrc[o] = (mPtr[o] + k) % 5;
          end
        end
      end
    end
  endtask

  task automatic modelUpdate();
    modelGrants();
    if (rst) begin
      mErr = 1'b0;
      for (int o = 0; o < 5; o++) begin
        mCred[o] = BUF_DEPTH;
        mPtr[o]  = 0;
        mOwn[o]  = 0;
        mLock[o] = 1'b0;
      end
    end else begin
      for (int o = 0; o < 5; o++) begin
        if (gsrc[o] >= 0 && !credit_inc[o]) mCred[o]--;
        else if (gsrc[o] < 0 && credit_inc[o]) begin
          if (mCred[o] == BUF_DEPTH) mErr = 1'b1;
          else mCred[o]++;
        end
        if (gsrc[o] >= 0) begin
          if (!mLock[o]) begin
            if (req_tail[gsrc[o]]) mPtr[o] = (gsrc[o] + 1) % 5;
            else begin
              mLock[o] = 1'b1;
              mOwn[o]  = gsrc[o];
            end
          end else if (req_tail[gsrc[o]]) begin
            mLock[o] = 1'b0;
            mPtr[o]  = (mOwn[o] + 1) % 5;
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [4:0] v, input logic [14:0] d, input logic [4:0] t,
                               input logic [4:0] inc, input logic r);
    exp_t e;
    req_valid  = v;
    req_dest   = d;
    req_tail   = t;
    credit_inc = inc;
    rst        = r;
    modelGrants();
    e.pop = '0;
    e.en  = '0;
    e.sel = '1;
    e.locked = '0;
    for (int o = 0; o < 5; o++) begin
      if (gsrc[o] >= 0) begin
        e.pop[gsrc[o]]  = 1'b1;
        e.en[o]         = 1'b1;
        e.sel[3*o +: 3] = 3'(gsrc[o]);
      end
      e.locked[o] = mLock[o] && !r;
    end
    e.err = mErr && !r;
    expQ.push_back(e);
  endtask

  task automatic compareOutputs();
    exp_t e;
    checkOutput("queue_depth", 32'(expQ.size()), 32'd1);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("in_pop", 32'(in_pop), 32'(e.pop));
      checkOutput("out_en", 32'(out_en), 32'(e.en));
      checkOutput("out_sel", 32'(out_sel), 32'(e.sel));
      checkOutput("out_locked", 32'(out_locked), 32'(e.locked));
      checkOutput("credit_err", 32'(credit_err), 32'(e.err));
    end
  endtask

  task automatic runCycle(input logic [4:0] v, input logic [14:0] d, input logic [4:0] t,
                          input logic [4:0] inc, input logic r);
    @(posedge clk);
    modelUpdate();
    #1;
    applyStimulus(v, d, t, inc, r);
    #4;
    compareOutputs();
  endtask

  function automatic logic [2:0] selOf(input int o);
    return out_sel[3*o +: 3];
  endfunction

  initial begin
    logic [2:0] rrExpect [4];
    rrExpect = '{3'd0, 3'd1, 3'd3, 3'd0};

    // Outputs are forced idle while reset is held, even with live requests.
    runCycle(5'b11111, dst(1, 0, 0, 0, 0), 5'b11111, 5'b11111, 1'b1);
    checkOutput("rst_in_pop", 32'(in_pop), 32'd0);
    checkOutput("rst_out_sel", 32'(out_sel), 32'h7fff);
    runCycle(5'b00000, dst(7, 7, 7, 7, 7), 5'b00000, 5'b00000, 1'b1);

    $display("[TB] single flit L->E");
    runCycle(5'b10000, dst(7, 7, 7, 7, 2), 5'b10000, 5'b00000, 1'b0);
    checkOutput("single_pop", 32'(in_pop), 32'h10);
    checkOutput("single_sel_e", 32'(selOf(2)), 32'd4);

    $display("[TB] round-robin N,S,W -> E");
    for (int c = 0; c < 4; c++) begin
      runCycle(5'b01011, dst(2, 2, 7, 2, 7), 5'b01011, 5'b00100, 1'b0);
      checkOutput("rr_sel_e", 32'(selOf(2)), 32'(rrExpect[c]));
    end

    $display("[TB] wormhole S -> L with N contending");
    runCycle(5'b00010, dst(7, 4, 7, 7, 7), 5'b00000, 5'b00000, 1'b0);
    checkOutput("worm_sel_1", 32'(selOf(4)), 32'd1);
    runCycle(5'b00011, dst(4, 4, 7, 7, 7), 5'b00001, 5'b00000, 1'b0);
    checkOutput("worm_sel_2", 32'(selOf(4)), 32'd1);
    checkOutput("worm_lock_2", 32'(out_locked[4]), 32'd1);
    runCycle(5'b00011, dst(4, 4, 7, 7, 7), 5'b00011, 5'b00000, 1'b0);
    checkOutput("worm_sel_3", 32'(selOf(4)), 32'd1);
    checkOutput("worm_lock_3", 32'(out_locked[4]), 32'd1);
    runCycle(5'b00001, dst(4, 7, 7, 7, 7), 5'b00001, 5'b00000, 1'b0);
    checkOutput("worm_sel_n", 32'(selOf(4)), 32'd0);

    $display("[TB] credit exhaustion W -> N");
    for (int c = 0; c < 4; c++) begin
      runCycle(5'b01000, dst(7, 7, 7, 0, 7), 5'b00000, 5'b00000, 1'b0);
      checkOutput("exh_grant", 32'(out_en[0]), 32'd1);
    end
    runCycle(5'b01000, dst(7, 7, 7, 0, 7), 5'b00000, 5'b00000, 1'b0);
    checkOutput("exh_stall", 32'(out_en[0]), 32'd0);
    runCycle(5'b01000, dst(7, 7, 7, 0, 7), 5'b00000, 5'b00000, 1'b0);
    runCycle(5'b01000, dst(7, 7, 7, 0, 7), 5'b00000, 5'b00001, 1'b0);
    checkOutput("exh_inc_cycle", 32'(out_en[0]), 32'd0);
    runCycle(5'b01000, dst(7, 7, 7, 0, 7), 5'b00000, 5'b00000, 1'b0);
    checkOutput("exh_after_inc", 32'(out_en[0]), 32'd1);
    runCycle(5'b01000, dst(7, 7, 7, 0, 7), 5'b00000, 5'b00001, 1'b0);
    runCycle(5'b01000, dst(7, 7, 7, 0, 7), 5'b01000, 5'b00000, 1'b0);
    checkOutput("exh_tail", 32'(out_en[0]), 32'd1);
    for (int c = 0; c < 4; c++) runCycle(5'b00000, dst(7, 7, 7, 7, 7), 5'b00000, 5'b00001, 1'b0);

    $display("[TB] simultaneous grant and credit on N");
    runCycle(5'b00100, dst(7, 7, 0, 7, 7), 5'b00100, 5'b00000, 1'b0);
    runCycle(5'b00100, dst(7, 7, 0, 7, 7), 5'b00100, 5'b00000, 1'b0);
    runCycle(5'b00100, dst(7, 7, 0, 7, 7), 5'b00100, 5'b00001, 1'b0);
    checkOutput("simul_grant", 32'(out_en[0]), 32'd1);
    runCycle(5'b00100, dst(7, 7, 0, 7, 7), 5'b00100, 5'b00000, 1'b0);
    runCycle(5'b00100, dst(7, 7, 0, 7, 7), 5'b00100, 5'b00000, 1'b0);
    checkOutput("simul_last", 32'(out_en[0]), 32'd1);
    runCycle(5'b00100, dst(7, 7, 0, 7, 7), 5'b00100, 5'b00000, 1'b0);
    checkOutput("simul_empty", 32'(out_en[0]), 32'd0);

    $display("[TB] credit overflow on S");
    runCycle(5'b00000, dst(7, 7, 7, 7, 7), 5'b00000, 5'b00010, 1'b0);
    runCycle(5'b00000, dst(7, 7, 7, 7, 7), 5'b00000, 5'b00000, 1'b0);
    checkOutput("overflow_err", 32'(credit_err), 32'd1);
    runCycle(5'b00000, dst(7, 7, 7, 7, 7), 5'b00000, 5'b00000, 1'b0);
    checkOutput("overflow_sticky", 32'(credit_err), 32'd1);

    $display("[TB] reset mid-packet W -> E");
    runCycle(5'b01000, dst(7, 7, 7, 2, 7), 5'b00000, 5'b00000, 1'b0);
    runCycle(5'b01000, dst(7, 7, 7, 2, 7), 5'b00000, 5'b00000, 1'b0);
    checkOutput("midpkt_locked", 32'(out_locked[2]), 32'd1);
    runCycle(5'b01000, dst(7, 7, 7, 2, 7), 5'b00000, 5'b00000, 1'b1);
    checkOutput("midpkt_rst_err", 32'(credit_err), 32'd0);
    runCycle(5'b00001, dst(2, 7, 7, 7, 7), 5'b00001, 5'b00000, 1'b0);
    checkOutput("after_rst_lock", 32'(out_locked), 32'd0);
    checkOutput("after_rst_sel_e", 32'(selOf(2)), 32'd0);
    checkOutput("after_rst_pop", 32'(in_pop), 32'd1);

    $display("[TB] random traffic");
    for (int c = 0; c < 80; c++) begin
      logic [4:0] inc;
      logic [14:0] d;
      for (int i = 0; i < 5; i++) d[3*i +: 3] = 3'($urandom_range(5, 0));
      for (int o = 0; o < 5; o++) inc[o] = ($urandom_range(3, 0) == 0);
      runCycle(5'($urandom), d, 5'($urandom), inc, ($urandom_range(39, 0) == 0));
    end

    @(posedge clk);
    $display("%0d/%0d checks passed", numPassed, numChecks);
    $finish;
  end

endmodule
